// File: rtl/data_mem_resp.sv
// Data-memory responder for the y_risc load/store port: one request at a time,
// WAIT_STATES wait cycles, RV32I byte/halfword/word access with error responses.
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_f3;
  logic        size_ok, misalign, oor, acc_err, do_write;
  logic [IDX_W-1:0] idx;
  logic [31:0] rword, load_val, wword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [3:0]  be;

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req_i) begin
        accept = 1'b1;
        if (WAIT_STATES == 0) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: if (cnt == 4'd1) begin
        state_nx   = RESP;
        enter_resp = 1'b1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so the
  // live request inputs are used while IDLE and the latched copy otherwise.
  always_comb begin
    acc_we    = (state == IDLE) ? we_i     : lat_we;
    acc_addr  = (state == IDLE) ? addr_i   : lat_addr;
    acc_wdata = (state == IDLE) ? wdata_i  : lat_wdata;
    acc_f3    = (state == IDLE) ? funct3_i : lat_f3;
  end

  always_comb begin
    case (acc_f3)
      3'd0, 3'd1, 3'd2: size_ok = 1'b1;
      3'd4, 3'd5:       size_ok = !acc_we;
      default:          size_ok = 1'b0;
    endcase
    misalign = ((acc_f3[1:0] == 2'd1) && acc_addr[0]) ||
               ((acc_f3[1:0] == 2'd2) && (acc_addr[1:0] != 2'd0));
    oor      = {2'b00, acc_addr[31:2]} >= DEPTH_WORDS;
    acc_err  = !size_ok || misalign || oor;
    do_write = enter_resp && acc_we && !acc_err && !rst_i;
    idx      = acc_addr[IDX_W+1:2];
  end

  always_comb begin
    rword = mem[idx];
    rbyte = rword[{acc_addr[1:0], 3'b000} +: 8];
    rhalf = acc_addr[1] ? rword[31:16] : rword[15:0];
    case (acc_f3)
      3'd0:    load_val = {{24{rbyte[7]}}, rbyte};
      3'd1:    load_val = {{16{rhalf[15]}}, rhalf};
      3'd2:    load_val = rword;
      3'd4:    load_val = {24'd0, rbyte};
      3'd5:    load_val = {16'd0, rhalf};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    be    = '0;
    wword = acc_wdata;
    case (acc_f3[1:0])
      2'd0: begin
        be    = 4'b0001 << acc_addr[1:0];
        wword = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_o <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_nx;
      busy_o  <= (state_nx != IDLE);
      ready_o <= enter_resp;
      err_o   <= enter_resp && acc_err;
      rdata_o <= (enter_resp && !acc_we && !acc_err) ? load_val : '0;
      if (accept)
        cnt <= 4'(WAIT_STATES);
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  // Request latch and array carry no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lat_we    <= we_i;
      lat_addr  <= addr_i;
      lat_wdata <= wdata_i;
      lat_f3    <= funct3_i;
    end
    if (do_write) begin
      for (int unsigned i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (0, 1 and 3 wait states) checked
// against a byte-array reference model with directed and random requests.
module tb_data_mem_resp;

  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic        req   [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];

  int errors = 0;
  int checks = 0;
  int ws_of [3] = '{0, 1, 3};
  logic [7:0] mb [3][DEPTH*4];

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .funct3_i(f3), .ready_o(ready[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .busy_o(busy[0]));

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .funct3_i(f3), .ready_o(ready[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .busy_o(busy[1]));

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .funct3_i(f3), .ready_o(ready[2]), .rdata_o(rdata[2]),
    .err_o(err[2]), .busy_o(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as bytes, access size 1/2/4, result built by arithmetic.
  task automatic model(input int w, input logic wv, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] fv,
                       output logic [31:0] rd, output logic e);
    int size;
    logic [31:0] v;
    size = 1 << fv[1:0];
    e = (fv == 3'd3) || (fv >= 3'd6) || (wv && fv >= 3'd4) ||
        ((a % size) != 0) || ((a / 4) >= DEPTH);
    rd = '0;
    if (!e) begin
      if (wv) begin
        for (int i = 0; i < size; i++) mb[w][a + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(mb[w][a + i]) << (8*i));
        if (!fv[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endtask

  task automatic xact(input int w, input logic wv, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] fv,
                      output logic [31:0] obs);
    logic [31:0] exp_rd;
    logic        exp_e;
    int          lat;
    we = wv; addr = a; wdata = d; f3 = fv; req[w] = 1'b1;
    @(posedge clk); #1;
    req[w] = 1'b0;
    we = 1'($urandom); addr = $urandom; wdata = $urandom; f3 = 3'($urandom);
    model(w, wv, a, d, fv, exp_rd, exp_e);
    check("busy_after_accept", 32'(busy[w]), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (ready[w]) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("latency", 32'(lat), 32'(ws_of[w] + 1));
    obs = rdata[w];
    check("rdata", rdata[w], exp_rd);
    check("err", 32'(err[w]), 32'(exp_e));
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ready[w]), 32'd0);
    check("idle_not_busy", 32'(busy[w]), 32'd0);
  endtask

  task automatic b2b(input int w);
    int ws, p;
    logic [31:0] exp_rd;
    logic exp_e;
    logic is_resp;
    ws = ws_of[w];
    p  = ws + 2;
    we = 1'b0; addr = 32'h10; wdata = '0; f3 = 3'd2;
    model(w, 1'b0, 32'h10, 32'h0, 3'd2, exp_rd, exp_e);
    req[w] = 1'b1;
    for (int c = 1; c <= 4*p + 2; c++) begin
      @(posedge clk); #1;
      if (c == 1 + 2*p) req[w] = 1'b0;
      is_resp = (c >= ws + 1) && (((c - ws - 1) % p) == 0) && (c <= ws + 1 + 2*p);
      check("b2b_ready", 32'(ready[w]), 32'(is_resp));
      if (is_resp) check("b2b_rdata", rdata[w], exp_rd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs;
    logic [31:0] a;
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; f3 = '0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", 32'(ready[i]), 32'd0);
      check("reset_rdata", rdata[i], 32'd0);
      check("reset_err", 32'(err[i]), 32'd0);
      check("reset_busy", 32'(busy[i]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++) xact(w, 1'b1, 32'(i*4), $urandom, 3'd2, obs);

    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, obs);
    xact(1, 1'b0, 32'h10, 32'h0, 3'd2, obs); check("dir_lw", obs, 32'hDEADBEEF);
    xact(1, 1'b0, 32'h13, 32'h0, 3'd0, obs); check("dir_lb", obs, 32'hFFFFFFDE);
    xact(1, 1'b0, 32'h13, 32'h0, 3'd4, obs); check("dir_lbu", obs, 32'h000000DE);
    xact(1, 1'b0, 32'h12, 32'h0, 3'd1, obs); check("dir_lh", obs, 32'hFFFFDEAD);
    xact(1, 1'b0, 32'h10, 32'h0, 3'd5, obs); check("dir_lhu", obs, 32'h0000BEEF);
    xact(1, 1'b1, 32'h11, 32'h55, 3'd0, obs);
    xact(1, 1'b1, 32'h12, 32'h1234, 3'd1, obs);
    xact(1, 1'b0, 32'h10, 32'h0, 3'd2, obs); check("dir_lw_merge", obs, 32'h123455EF);

    xact(1, 1'b0, 32'h12, 32'h0, 3'd2, obs); check("err_lw_misalign", obs, 32'h0);
    xact(1, 1'b1, 32'h11, 32'hFFFF, 3'd1, obs);
    xact(1, 1'b1, DEPTH*4, 32'h0BADF00D, 3'd2, obs);
    xact(1, 1'b0, 32'h10, 32'h0, 3'd3, obs); check("err_f3_load", obs, 32'h0);
    xact(1, 1'b1, 32'h10, 32'hFFFFFFFF, 3'd3, obs);
    xact(1, 1'b1, 32'h10, 32'hFFFFFFFF, 3'd4, obs);
    xact(1, 1'b0, 32'h10, 32'h0, 3'd2, obs); check("err_mem_intact", obs, 32'h123455EF);

    b2b(1);
    b2b(0);

    xact(2, 1'b1, 32'h20, 32'h11112222, 3'd2, obs);
    we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; f3 = 3'd2; req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait_ready", 32'(ready[2]), 32'd0);
    check("rst_wait_rdata", rdata[2], 32'd0);
    check("rst_wait_err", 32'(err[2]), 32'd0);
    check("rst_wait_busy", 32'(busy[2]), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("rst_no_resp", 32'(ready[2]), 32'd0);
    end
    xact(2, 1'b0, 32'h20, 32'h0, 3'd2, obs); check("rst_no_commit", obs, 32'h11112222);

    for (int n = 0; n < 60; n++) begin
      int w;
      w = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) a = DEPTH*4 + $urandom_range(0, 15);
      else a = $urandom_range(0, 63);
      xact(w, 1'($urandom), a, $urandom, 3'($urandom_range(0, 7)), obs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
